// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory path and its
// 16-bit asynchronous SRAM controller.
package arm_mem_pkg;

    localparam int SRAM_ADDR_LEN = 18;
    localparam int SRAM_DATA_LEN = 16;
    localparam int WORD_IDX_LEN  = SRAM_ADDR_LEN - 1;
    localparam int WAIT_CNT_W    = 4;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } sram_state_e;

    // 32-bit word index inside the SRAM window; out-of-range offsets wrap.
    function automatic logic [WORD_IDX_LEN-1:0] word_index(input logic [31:0] address,
                                                           input logic [31:0] base);
        return WORD_IDX_LEN'((address - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter that times one SRAM half-word phase; tc flags the
// final cycle, tc_next flags that the next cycle will be the final one.
module sram_wait_counter
    import arm_mem_pkg::*;
#(
    parameter int WIDTH = WAIT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc,
    output logic             tc_next
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    assign tc      = (count_q == '0);
    assign tc_next = (count_d == '0);

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_sram_ctrl.sv
// MEM-stage data-memory responder: one 32-bit access as two 16-bit SRAM phases.
// Optional one-entry read hit buffer enabled by defining SRAM_CTRL_HIT_BUF_EN.
module mem_sram_ctrl
    import arm_mem_pkg::*;
#(
    parameter int          WAIT_CYCLES = 3,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic                     wr_en,
    input  logic [31:0]              address,
    input  logic [31:0]              write_data,
    output logic [31:0]              read_data,
    output logic                     ready,
    output logic [SRAM_ADDR_LEN-1:0] sram_addr,
    output logic [SRAM_DATA_LEN-1:0] sram_dq_out,
    output logic                     sram_dq_oe,
    input  logic [SRAM_DATA_LEN-1:0] sram_dq_in,
    output logic                     sram_we_n
);

    sram_state_e state_q, state_d;
    logic                     is_wr_q, is_wr_d;
    logic [WORD_IDX_LEN-1:0]  idx_q, idx_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [SRAM_DATA_LEN-1:0] stage_q, stage_d;
    logic [31:0]              read_data_q, read_data_d;
    logic [SRAM_ADDR_LEN-1:0] sram_addr_q, sram_addr_d;
    logic [SRAM_DATA_LEN-1:0] dq_out_q, dq_out_d;
    logic                     oe_q, oe_d;
    logic                     we_n_q, we_n_d;

    logic                     cnt_load, cnt_tc, cnt_tc_next;
    logic [WORD_IDX_LEN-1:0]  req_idx;
    logic                     hit;

    assign req_idx = word_index(address, BASE_ADDR);

    sram_wait_counter #(.WIDTH(WAIT_CNT_W)) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (WAIT_CNT_W'(WAIT_CYCLES - 1)),
        .tc       (cnt_tc),
        .tc_next  (cnt_tc_next)
    );

`ifdef SRAM_CTRL_HIT_BUF_EN
    logic                    buf_valid_q, buf_valid_d;
    logic [WORD_IDX_LEN-1:0] buf_idx_q, buf_idx_d;
    logic [31:0]             buf_data_q, buf_data_d;

    assign hit = rd_en && !wr_en && buf_valid_q && (buf_idx_q == req_idx);
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        stage_d     = stage_q;
        read_data_d = read_data_q;
        cnt_load    = 1'b0;
`ifdef SRAM_CTRL_HIT_BUF_EN
        buf_valid_d = buf_valid_q;
        buf_idx_d   = buf_idx_q;
        buf_data_d  = buf_data_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (rd_en || wr_en) begin
                    is_wr_d = wr_en;
                    idx_d   = req_idx;
                    wdata_d = write_data;
                    if (hit) begin
                        state_d = ST_DONE;
`ifdef SRAM_CTRL_HIT_BUF_EN
                        read_data_d = buf_data_q;
`endif
                    end else begin
                        state_d  = ST_LOW;
                        cnt_load = 1'b1;
                    end
                end
            end
            ST_LOW: begin
                if (cnt_tc) begin
                    state_d  = ST_HIGH;
                    cnt_load = 1'b1;
                    if (!is_wr_q) stage_d = sram_dq_in;
                end
            end
            ST_HIGH: begin
                if (cnt_tc) begin
                    state_d = ST_DONE;
                    if (is_wr_q) begin
`ifdef SRAM_CTRL_HIT_BUF_EN
                        if (buf_valid_q && (buf_idx_q == idx_q)) buf_data_d = wdata_q;
`endif
                    end else begin
                        read_data_d = {sram_dq_in, stage_q};
`ifdef SRAM_CTRL_HIT_BUF_EN
                        buf_valid_d = 1'b1;
                        buf_idx_d   = idx_q;
                        buf_data_d  = {sram_dq_in, stage_q};
`endif
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // SRAM pins are registered from next-state values so the strobe never glitches.
    always_comb begin
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        oe_d        = 1'b0;
        we_n_d      = 1'b1;
        if (state_d == ST_LOW || state_d == ST_HIGH) begin
            sram_addr_d = {idx_d, (state_d == ST_HIGH)};
            if (is_wr_d) begin
                oe_d     = 1'b1;
                dq_out_d = (state_d == ST_HIGH) ? wdata_d[31:16] : wdata_d[15:0];
                we_n_d   = cnt_tc_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            is_wr_q     <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            stage_q     <= '0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            oe_q        <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            stage_q     <= stage_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            oe_q        <= oe_d;
            we_n_q      <= we_n_d;
        end
    end

`ifdef SRAM_CTRL_HIT_BUF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid_q <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
        end
    end

    // NOTE: buffer payload is storage, not control; clearing valid on reset is enough, so it has no reset.
    always_ff @(posedge clk) begin
        buf_idx_q  <= buf_idx_d;
        buf_data_q <= buf_data_d;
    end
`endif

    assign read_data   = read_data_q;
    assign ready       = !(rd_en || wr_en) || (state_q == ST_DONE);
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = oe_q;
    assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Self-checking bench for mem_sram_ctrl: transaction-level reference model
// compared every cycle, plus directed literal expectations.
module tb_mem_sram_ctrl;

    localparam int W      = 3;
    localparam int BASE   = 1024;
    localparam int DONE_K = 2 * W + 1;
    localparam int HW_N   = 262144;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;

    int checks   = 0;
    int failures = 0;

    logic [15:0] sram_mem [0:HW_N-1];
    logic [15:0] ref_mem  [0:HW_N-1];

    logic [17:0] wlog_addr [$];
    logic [15:0] wlog_data [$];

    // reference model state: m_k = cycle position inside the current access
    int          m_k     = 0;
    logic        m_wr    = 1'b0;
    int          m_idx   = 0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata = '0;
`ifdef SRAM_CTRL_HIT_BUF_EN
    logic        mb_valid = 1'b0;
    int          mb_idx   = 0;
    logic [31:0] mb_data  = '0;
`endif

    always #5 clk = ~clk;

    mem_sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024)) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n)
    );

    // asynchronous SRAM device
    assign sram_dq_in = sram_mem[sram_addr];
    always @(posedge clk) begin
        if (rst && !sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_out;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // per-cycle compare against the model, then advance the model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("rst_read_data", read_data, 32'h0);
                check("rst_sram_we_n", {31'b0, sram_we_n}, 32'h1);
                check("rst_sram_dq_oe", {31'b0, sram_dq_oe}, 32'h0);
                check("rst_sram_addr", {14'b0, sram_addr}, 32'h0);
                check("rst_sram_dq_out", {16'b0, sram_dq_out}, 32'h0);
                m_k     = 0;
                m_rdata = '0;
`ifdef SRAM_CTRL_HIT_BUF_EN
                mb_valid = 1'b0;
`endif
            end else begin
                check("ready", {31'b0, ready}, {31'b0, (!(rd_en || wr_en) || m_k == DONE_K)});
                check("read_data", read_data, m_rdata);
                if (m_k >= 1 && m_k <= 2 * W) begin
                    int hi, j;
                    hi = (m_k > W) ? 1 : 0;
                    j  = hi ? m_k - W : m_k;
                    check("sram_addr", {14'b0, sram_addr}, 32'(m_idx * 2 + hi));
                    check("sram_dq_oe", {31'b0, sram_dq_oe}, {31'b0, m_wr});
                    check("sram_we_n", {31'b0, sram_we_n}, {31'b0, !(m_wr && j < W)});
                    if (m_wr)
                        check("sram_dq_out", {16'b0, sram_dq_out},
                              {16'b0, (hi != 0) ? m_wdata[31:16] : m_wdata[15:0]});
                end
                if (m_k == 0) begin
                    if (rd_en || wr_en) begin
                        m_wr    = wr_en;
                        m_idx   = int'(((address - BASE) >> 2) & 32'h1FFFF);
                        m_wdata = write_data;
                        m_k     = 1;
`ifdef SRAM_CTRL_HIT_BUF_EN
                        if (!wr_en && mb_valid && mb_idx == m_idx) begin
                            m_k     = DONE_K;
                            m_rdata = mb_data;
                        end
`endif
                    end
                end else if (m_k == 2 * W) begin
                    m_k = DONE_K;
                    if (m_wr) begin
                        ref_mem[2 * m_idx]     = m_wdata[15:0];
                        ref_mem[2 * m_idx + 1] = m_wdata[31:16];
`ifdef SRAM_CTRL_HIT_BUF_EN
                        if (mb_valid && mb_idx == m_idx) mb_data = m_wdata;
`endif
                    end else begin
                        m_rdata = {ref_mem[2 * m_idx + 1], ref_mem[2 * m_idx]};
`ifdef SRAM_CTRL_HIT_BUF_EN
                        mb_valid = 1'b1;
                        mb_idx   = m_idx;
                        mb_data  = m_rdata;
`endif
                    end
                end else if (m_k == DONE_K) begin
                    m_k = 0;
                end else begin
                    m_k++;
                end
            end
        end
    end

    // log of every cycle the write strobe is active
    initial begin
        forever begin
            @(negedge clk);
            if (rst && !sram_we_n) begin
                wlog_addr.push_back(sram_addr);
                wlog_data.push_back(sram_dq_out);
            end
        end
    end

    // one access: request held until ready; lat = cycles from request to ready
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, output int lat);
        bit done;
        wlog_addr.delete();
        wlog_data.delete();
        rd_en      = rd;
        wr_en      = wr;
        address    = addr;
        write_data = data;
        lat        = 0;
        done       = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (ready) done = 1'b1;
            else lat++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL access_timeout: ready never rose, addr %h", addr);
        end
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        for (int i = 0; i < HW_N; i++) begin
            sram_mem[i] = 16'(i) ^ 16'hA5A5;
            ref_mem[i]  = 16'(i) ^ 16'hA5A5;
        end
        rst        = 1'b0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        address    = '0;
        write_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // write 0xDEADBEEF to 1024
        access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, lat);
        check("wr_latency", 32'(lat), 32'd7);
        check("wr_strobe_cycles", 32'(wlog_addr.size()), 32'd4);
        if (wlog_addr.size() == 4) begin
            check("wr_addr_lo", {14'b0, wlog_addr[0]}, 32'd0);
            check("wr_data_lo", {16'b0, wlog_data[1]}, 32'h0000BEEF);
            check("wr_addr_hi", {14'b0, wlog_addr[3]}, 32'd1);
            check("wr_data_hi", {16'b0, wlog_data[2]}, 32'h0000DEAD);
        end
        check("sram_hw0", {16'b0, sram_mem[0]}, 32'h0000BEEF);
        check("sram_hw1", {16'b0, sram_mem[1]}, 32'h0000DEAD);

        // read it back and confirm the value holds
        access(1'b1, 1'b0, 32'd1024, 32'h0, lat);
        check("rd_latency", 32'(lat), 32'd7);
        check("rd_data", read_data, 32'hDEADBEEF);
        repeat (3) @(posedge clk);
        #1 check("rd_data_hold", read_data, 32'hDEADBEEF);

        // address 1028 maps to half-words 2 and 3
        access(1'b0, 1'b1, 32'd1028, 32'hCAFEF00D, lat);
        if (wlog_addr.size() == 4) begin
            check("a1028_lo", {14'b0, wlog_addr[0]}, 32'd2);
            check("a1028_hi", {14'b0, wlog_addr[3]}, 32'd3);
        end else begin
            check("a1028_strobes", 32'(wlog_addr.size()), 32'd4);
        end

        // 1024 + 2^19 wraps to half-words 0 and 1
        access(1'b0, 1'b1, 32'd1024 + 32'd524288, 32'h0BADF00D, lat);
        if (wlog_addr.size() == 4) begin
            check("wrap_lo", {14'b0, wlog_addr[0]}, 32'd0);
            check("wrap_hi", {14'b0, wlog_addr[3]}, 32'd1);
        end else begin
            check("wrap_strobes", 32'(wlog_addr.size()), 32'd4);
        end
        access(1'b1, 1'b0, 32'd1024, 32'h0, lat);
        check("wrap_rd_data", read_data, 32'h0BADF00D);

        // rd_en and wr_en together act as a write
        access(1'b1, 1'b1, 32'd1028, 32'h12345678, lat);
        check("both_rd_unchanged", read_data, 32'h0BADF00D);
        check("both_sram_hw2", {16'b0, sram_mem[2]}, 32'h00005678);
        check("both_sram_hw3", {16'b0, sram_mem[3]}, 32'h00001234);
        access(1'b1, 1'b0, 32'd1028, 32'h0, lat);
        check("both_rd_back", read_data, 32'h12345678);

        // reset during the HIGH phase of a write
        rd_en      = 1'b0;
        wr_en      = 1'b1;
        address    = 32'd2048;
        write_data = 32'hFFFF0000;
        repeat (5) @(posedge clk);
        #1 check("mid_we_active", {31'b0, sram_we_n}, 32'h0);
        rst = 1'b0;
        #1;
        check("mid_rst_we_n", {31'b0, sram_we_n}, 32'h1);
        check("mid_rst_oe", {31'b0, sram_dq_oe}, 32'h0);
        check("mid_rst_read_data", read_data, 32'h0);
        @(posedge clk);
        #1 wr_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

`ifdef SRAM_CTRL_HIT_BUF_EN
        access(1'b1, 1'b0, 32'd1024, 32'h0, lat);
        check("buf_miss_latency", 32'(lat), 32'd7);
        access(1'b1, 1'b0, 32'd1024, 32'h0, lat);
        check("buf_hit_latency", 32'(lat), 32'd1);
        check("buf_hit_data", read_data, 32'h0BADF00D);
        access(1'b0, 1'b1, 32'd1024, 32'h0, lat);
        access(1'b1, 1'b0, 32'd1024, 32'h0, lat);
        check("buf_upd_latency", 32'(lat), 32'd1);
        check("buf_upd_data", read_data, 32'h0);
`else
        access(1'b1, 1'b0, 32'd1024, 32'h0, lat);
        check("rpt_latency_a", 32'(lat), 32'd7);
        access(1'b1, 1'b0, 32'd1024, 32'h0, lat);
        check("rpt_latency_b", 32'(lat), 32'd7);
        check("rpt_data", read_data, 32'h0BADF00D);
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_sram_ctrl.md
# mem_sram_ctrl

Responder side of the MEM stage's data-memory access. Accepts one 32-bit read or write request per access from the MEM stage and serves it over an external 16-bit asynchronous SRAM as two half-word transfers. Drives `ready` low while an access is in flight so the top level can derive the pipeline-wide `freeze`.

## Interface
- `WAIT_CYCLES`, 3: cycles each SRAM half-word phase is held; legal range 2..15.
- `BASE_ADDR`, 32'd1024: byte address mapped to SRAM word 0.

- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rd_en` in 1: read request from MEM stage, held until `ready`.
- `wr_en` in 1: write request from MEM stage, held until `ready`.
- `address` in 32: byte address; bits [1:0] ignored.
- `write_data` in 32: store data, held until `ready`.
- `read_data` out 32: load data, registered.
- `ready` out 1: high = no access pending or current access completing this cycle.
- `sram_addr` out 18: half-word address to SRAM.
- `sram_dq_out` out 16: data driven to SRAM.
- `sram_dq_oe` out 1: top-level tristate enable for the DQ bus.
- `sram_dq_in` in 16: data sampled from SRAM.
- `sram_we_n` out 1: SRAM write strobe, active-low.

## Operation
- Offset = `address - BASE_ADDR`; word index = offset[18:2]; low half at `sram_addr = {idx,1'b0}`, high half at `{idx,1'b1}`. Out-of-range addresses wrap modulo 2^18 half-words; no error.
- FSM: IDLE -> LOW -> HIGH -> DONE -> IDLE.
  - IDLE: request (`rd_en|wr_en`) latches op, index, `write_data`; go to LOW. Otherwise stay.
  - LOW / HIGH: each held exactly `WAIT_CYCLES` cycles via wait counter, then advance.
  - DONE: one cycle, then IDLE.
- `wr_en` and `rd_en` both high: treated as a write; `read_data` unchanged.
- Write phase: `sram_dq_oe`=1 throughout; `sram_dq_out` = latched half (LOW: [15:0], HIGH: [31:16]); `sram_we_n`=0 for the first `WAIT_CYCLES-1` cycles, 1 on the last (address/data hold).
- Read phase: `sram_dq_oe`=0, `sram_we_n`=1; `sram_dq_in` sampled on the last cycle of LOW into [15:0] and HIGH into [31:16] of a staging register; `read_data` loads the full word entering DONE and holds until the next read completes.
- `ready` = !(`rd_en`|`wr_en`) | (state==DONE), combinational.
- Request inputs changing mid-access are ignored (latched copy used).

## Timing
- Reset values: state IDLE, counter 0, `read_data` 0, `sram_addr` 0, `sram_dq_out` 0, `sram_dq_oe` 0, `sram_we_n` 1; `ready` follows its equation.
- Request asserted in cycle 0 (IDLE): `ready` low in cycles 0..2·W, high in cycle 2·W+1 (DONE); W=3 -> `ready` high in cycle 7.
- Request still high in the cycle after DONE is a new access (MEM stage is expected to have advanced).
- Reset asserted mid-access: immediate return to reset values; the SRAM write may be partial; no completion signalled.

## Configuration
- `SRAM_CTRL_HIT_BUF_EN` defined: one-entry read buffer (valid, index, data). Read in IDLE whose index matches a valid entry skips LOW/HIGH and goes straight to DONE (`ready` high in cycle 1), `read_data` loaded from buffer. Each completed read fills it; a write to the buffered index updates its data; reset clears valid.
- Not defined: every access takes the full 2·W+2 cycles; no buffer logic.

## Structure
- Shared package `arm_mem_pkg`: FSM state enum, `SRAM_ADDR_LEN`=18, `SRAM_DATA_LEN`=16, default `BASE_ADDR`.
- Sub-module `sram_wait_counter`: loadable down-counter with terminal-count flag, reused by both phases.

## Test plan
- Write 0xDEADBEEF to 1024, W=3 -> `sram_addr` 0 then 1, `sram_dq_out` 0xBEEF then 0xDEAD, `sram_we_n` low 2 cycles per phase, `ready` high in cycle 7.
- Read 1024 with model SRAM holding 0xBEEF/0xDEAD -> `read_data`=0xDEADBEEF in DONE, held afterward.
- Address 1028 -> half-words 2 and 3; address 1024+2^19 -> wraps to half-words 0 and 1.
- `rd_en` and `wr_en` both high with 0x12345678 -> write performed, `read_data` unchanged.
- `rst` low in HIGH phase -> next cycle state IDLE, `sram_we_n`=1, `sram_dq_oe`=0, `read_data`=0.
- With `SRAM_CTRL_HIT_BUF_EN`: repeat read of 1024 -> `ready` high in cycle 1, same data; after write 0x0 to 1024, read returns 0x0.
